// File: rtl/simd_pcpi_unit.sv
// PCPI responder for custom-0 packed-8 SIMD ops: wrap/saturating add/sub and a 4-lane signed dot product.
// Simple ops answer in one cycle; the dot product walks one lane per cycle through a shared multiplier.
//
// state | meaning
// IDLE  | waiting for a claimed instruction
// MAC   | dot product in progress, one lane per cycle
// RESP  | result valid, ready/wr pulse for one cycle
module simd_pcpi_unit #(
  parameter logic [6:0] CUSTOM_OPCODE = 7'b0001011,
  parameter logic [6:0] FUNCT7        = 7'b0000101,
  parameter bit         ENABLE_DOT    = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  typedef enum logic [1:0] {IDLE, MAC, RESP} state_t;

  state_t      state, state_nx;
  logic [2:0]  funct3;
  logic        match, is_dot, claim;
  logic [31:0] a_q, b_q, acc, simple_res, prod_ext;
  logic [1:0]  lane;
  logic [7:0]  a_lane, b_lane;
  logic signed [15:0] prod;
  logic [8:0]  la, lb, ls;
  logic        unused_insn;

  assign funct3      = pcpi_insn[14:12];
  assign match       = pcpi_valid && (pcpi_insn[6:0] == CUSTOM_OPCODE) && (pcpi_insn[31:25] == FUNCT7);
  assign is_dot      = ENABLE_DOT && (funct3 == 3'b100);
  assign claim       = match && (!funct3[2] || is_dot);
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // funct3[0] selects subtract, funct3[1] selects signed saturation
  always_comb begin
    simple_res = '0;
    la = '0;
    lb = '0;
    ls = '0;
    for (int i = 0; i < 4; i++) begin
      la = {pcpi_rs1[8*i+7], pcpi_rs1[8*i +: 8]};
      lb = {pcpi_rs2[8*i+7], pcpi_rs2[8*i +: 8]};
      ls = funct3[0] ? (la - lb) : (la + lb);
      if (funct3[1] && (ls[8] != ls[7]))
        simple_res[8*i +: 8] = ls[8] ? 8'h80 : 8'h7F;
      else
        simple_res[8*i +: 8] = ls[7:0];
    end
  end

  assign a_lane   = a_q[{lane, 3'b000} +: 8];
  assign b_lane   = b_q[{lane, 3'b000} +: 8];
  assign prod     = $signed(a_lane) * $signed(b_lane);
  assign prod_ext = {{16{prod[15]}}, prod};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (claim) state_nx = is_dot ? MAC : RESP;
      MAC: begin
        if (!pcpi_valid)       state_nx = IDLE;
        else if (lane == 2'd3) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pcpi_ready = (state == RESP);
    pcpi_wr    = (state == RESP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcpi_wait <= 1'b0;
      pcpi_rd   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      lane      <= '0;
    end else begin
      pcpi_wait <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          if (claim && is_dot) begin
            a_q  <= pcpi_rs1;
            b_q  <= pcpi_rs2;
            acc  <= '0;
            lane <= '0;
          end else if (claim) begin
            pcpi_rd <= simple_res;
          end
        end
        MAC: begin
          if (pcpi_valid) begin
            if (lane == 2'd3) pcpi_rd <= acc + prod_ext;
            else              acc     <= acc + prod_ext;
            lane <= lane + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_pcpi_unit.sv
// Randomized bench for simd_pcpi_unit against an integer-arithmetic lane model,
// plus directed vectors, unclaimed encodings, abort and mid-operation reset.
module tb_simd_pcpi_unit;

  logic        clk;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  int n_checks = 0;
  int n_errors = 0;

  simd_pcpi_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int clamp8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Lane-by-lane integer model of the instruction set
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    logic signed [7:0] xa, xb;
    int x, y, r, dot;
    res = '0;
    dot = 0;
    for (int i = 0; i < 4; i++) begin
      xa = a[8*i +: 8];
      xb = b[8*i +: 8];
      x = xa;
      y = xb;
      case (f3)
        3'd0:    r = x + y;
        3'd1:    r = x - y;
        3'd2:    r = clamp8(x + y);
        3'd3:    r = clamp8(x - y);
        default: r = 0;
      endcase
      dot += x * y;
      res[8*i +: 8] = 8'(r);
    end
    return (f3 == 3'd4) ? 32'(dot) : res;
  endfunction

  function automatic logic [31:0] mk_insn(input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] opc);
    logic [31:0] rnd;
    rnd = $urandom;
    return {f7, rnd[24:15], f3, rnd[11:7], opc};
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int want_lat, lat;
    bit seen;
    want_lat = (f3 == 3'd4) ? 5 : 1;
    lat = 0;
    seen = 0;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(f3, 7'b0000101, 7'b0001011);
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        pcpi_rs1 = $urandom;
        pcpi_rs2 = $urandom;
      end
      check({tag, " wait"}, 32'(pcpi_wait), 32'd1);
      if (pcpi_ready) begin
        seen = 1;
        lat = k;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(want_lat));
    check({tag, " rd"}, pcpi_rd, exp);
    check({tag, " wr"}, 32'(pcpi_wr), 32'd1);
    @(negedge clk);
    pcpi_valid = 1'b0;
    check({tag, " ready pulse"}, 32'(pcpi_ready), 32'd0);
    check({tag, " wait idle"}, 32'(pcpi_wait), 32'd0);
    check({tag, " rd hold"}, pcpi_rd, exp);
  endtask

  task automatic unclaimed(input string tag, input logic [31:0] insn);
    logic any;
    any = 1'b0;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = $urandom;
    pcpi_rs2   = $urandom;
    repeat (20) begin
      @(negedge clk);
      any = any | pcpi_wait | pcpi_ready | pcpi_wr;
    end
    check(tag, 32'(any), 32'd0);
    pcpi_valid = 1'b0;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        any;
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    repeat (2) @(negedge clk);
    check("reset ready", 32'(pcpi_ready), 32'd0);
    check("reset wr",    32'(pcpi_wr),    32'd0);
    check("reset wait",  32'(pcpi_wait),  32'd0);
    check("reset rd",    pcpi_rd,         32'd0);
    resetn = 1'b1;

    run_op("padd8",  3'd0, 32'h7F0180FF, 32'h01018001, 32'h80020000);
    run_op("padds8", 3'd2, 32'h7F0180FF, 32'h01018001, 32'h7F028000);
    run_op("psubs8", 3'd3, 32'h80000000, 32'h01000000, 32'h80000000);
    run_op("psub8",  3'd1, 32'h80000000, 32'h01000000, 32'h7F000000);
    run_op("pdot8 small", 3'd4, 32'h01020304, 32'h05060708, 32'h00000046);
    run_op("pdot8 minmin", 3'd4, 32'h80808080, 32'h80808080, 32'h00010000);
    run_op("pdot8 maxmin", 3'd4, 32'h7F7F7F7F, 32'h80808080, 32'hFFFF0200);

    unclaimed("unclaimed f3=101", mk_insn(3'd5, 7'b0000101, 7'b0001011));
    unclaimed("unclaimed f3=111", mk_insn(3'd7, 7'b0000101, 7'b0001011));
    unclaimed("unclaimed f7=0",   mk_insn(3'd0, 7'b0000000, 7'b0001011));
    unclaimed("unclaimed opcode", mk_insn(3'd4, 7'b0000101, 7'b0110011));

    // abort in the second MAC cycle, then a simple op must be unaffected
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(3'd4, 7'b0000101, 7'b0001011);
    pcpi_rs1   = 32'h7F7F7F7F;
    pcpi_rs2   = 32'h7F7F7F7F;
    repeat (2) @(negedge clk);
    pcpi_valid = 1'b0;
    @(negedge clk);
    check("abort wait", 32'(pcpi_wait), 32'd0);
    any = pcpi_ready;
    repeat (8) begin
      @(negedge clk);
      any = any | pcpi_ready | pcpi_wait;
    end
    check("abort no ready", 32'(any), 32'd0);
    run_op("padd8 after abort", 3'd0, 32'h01020304, 32'h10203040, 32'h11223344);

    // asynchronous reset in the middle of MAC
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(3'd4, 7'b0000101, 7'b0001011);
    pcpi_rs1   = 32'h11223344;
    pcpi_rs2   = 32'h55667788;
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async rst wait",  32'(pcpi_wait),  32'd0);
    check("async rst ready", 32'(pcpi_ready), 32'd0);
    check("async rst wr",    32'(pcpi_wr),    32'd0);
    check("async rst rd",    pcpi_rd,         32'd0);
    @(negedge clk);
    pcpi_valid = 1'b0;
    resetn = 1'b1;
    any = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any = any | pcpi_ready;
    end
    check("post reset no ready", 32'(any), 32'd0);
    run_op("pdot8 after reset", 3'd4, 32'h01FF7F80, 32'hFE037F80, model(3'd4, 32'h01FF7F80, 32'hFE037F80));

    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 4));
      a  = $urandom;
      b  = $urandom;
      if (n % 3 == 0) begin
        a = {$urandom_range(0, 1) ? 8'h80 : 8'h7F, a[23:0]};
        b = {$urandom_range(0, 1) ? 8'h80 : 8'h7F, b[23:0]};
      end
      run_op($sformatf("rand%0d f3=%0d", n, f3), f3, a, b, model(f3, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
